fmac_arb_ctrl: RTL and testbench
================================

Name: fmac_arb_ctrl

Overview:
Shares one multi-cycle FMAC datapath (result = a*b + c) between two requesters. The block arbitrates round-robin, latches the operand triple and pulses the datapath start. It counts the fixed datapath latency, captures the result and returns it to the granted requester over a valid/ready response channel. It also precomputes the product sign (XOR of operand signs) for the datapath's sign logic. One operation is in flight at a time.

Parameters:
WIDTH, 16, operand/result width; MSB is the sign bit
LAT, 4, datapath latency in cycles from dp_go to valid dp_res (LAT >= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 operand triple valid
req0_ready  output  1  requester 0 triple accepted this cycle
req0_a, req0_b, req0_c  input  WIDTH  requester 0 operands
req1_valid, req1_ready, req1_a, req1_b, req1_c  same as requester 0, for requester 1
resp0_valid  output  1  result available for requester 0
resp0_ready  input  1  requester 0 takes result
resp1_valid, resp1_ready  same, requester 1
resp_data  output  WIDTH  result, shared by both response channels
dp_go  output  1  one-cycle start pulse to datapath
dp_a, dp_b, dp_c  output  WIDTH  latched operands, stable from dp_go until next accept
dp_psign  output  1  dp_a[WIDTH-1] XOR dp_b[WIDTH-1]
dp_res  input  WIDTH  datapath result, sampled at end of latency

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.
- States: IDLE, RUN, DONE.
- Reset, applied in any state including mid-operation:
  - state=IDLE; rr pointer=0 (requester 0 preferred).
  - dp_go=0; resp*_valid=0; dp_a/b/c=0; resp_data=0; cnt=0; grant=0.
  - Any in-flight result is discarded.
- IDLE:
  - Combinational grant: if only one valid, grant that one. If both valid, grant the pointer's requester.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. It is never high outside IDLE.
  - On accept: latch a/b/c into dp_a/b/c, register granted id, cnt=0, go RUN.
- RUN:
  - dp_go=1 on the first RUN cycle only.
  - cnt increments each cycle.
  - When cnt==LAT-1, resp_data<=dp_res and go DONE.
- DONE:
  - resp{grant}_valid=1 and resp_data held. The other requester's resp valid stays 0.
  - When the granted resp_ready=1: go IDLE, rr pointer <= other requester.
  - resp_ready may be held low indefinitely.
  - The non-granted requester's resp_ready is ignored.
- Timing: accept in cycle T; dp_go in T+1; dp_res sampled at end of T+LAT; resp_valid from T+LAT+1.
  - Minimum cycles from accept to next accept: LAT+2.
- Pointer updates only on response completion, so a requester holding valid gets at most one extra grant before the other.
- Requests arriving while not IDLE wait; valid must be held by the requester until ready.
- dp_psign is combinational from the dp_a/dp_b registers.

Optional Feature:
FMAC_STAT_EN:
- Defined: adds output ops_done (16 bits). It resets to 0, increments on each completed response handshake and wraps 16'hFFFF -> 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Single op, LAT=4, bench datapath returns a^b^c after LAT cycles. req0 a=16'h3C00, b=16'hC000, c=16'h0001 accepted at T -> dp_go at T+1, dp_psign=1, resp0_valid at T+5 with resp_data=16'hFC01, resp1_valid stays 0.
- Both valid continuously from reset -> grants alternate 0,1,0,1. Each accept is LAT+2=6 cycles apart with resp_ready tied 1.
- Response back-pressure: hold resp1_ready=0 for 10 cycles in DONE -> resp1_valid and resp_data stable, req0_ready stays 0, no second dp_go.
- Reset mid-RUN, at cnt=2 -> next cycle IDLE, all outputs 0, no resp_valid. The following req1 is accepted normally.
- Operand stability: change req0_a after accept -> dp_a unchanged until the next accept.
- FMAC_STAT_EN defined: 65537 completed ops -> ops_done=1; undefined: bench compiles without ops_done.

Source files
------------

// File: rtl/fmac_arb_ctrl_if.sv
// Handshake bundle for the shared FMAC controller: two request channels,
// two response channels sharing one data bus, and the datapath drive/return.
interface fmac_arb_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req0_c;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] req1_c;

    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_data;

    logic             dp_go;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [WIDTH-1:0] dp_c;
    logic             dp_psign;
    logic [WIDTH-1:0] dp_res;

    // Controller side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_c,
        input  req1_valid, req1_a, req1_b, req1_c,
        input  resp0_ready, resp1_ready, dp_res,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data,
        output dp_go, dp_a, dp_b, dp_c, dp_psign
    );

    // Requester / datapath side
    modport master (
        output req0_valid, req0_a, req0_b, req0_c,
        output req1_valid, req1_a, req1_b, req1_c,
        output resp0_ready, resp1_ready, dp_res,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data,
        input  dp_go, dp_a, dp_b, dp_c, dp_psign
    );
endinterface

// File: rtl/fmac_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one fixed-latency FMAC datapath between two requesters.
// Optional macro FMAC_STAT_EN adds the 16-bit ops_done completed-response counter.
module fmac_arb_ctrl #(
    parameter int WIDTH = 16,
    parameter int LAT   = 4
) (
    input  logic clk,
    input  logic rst,
    fmac_arb_ctrl_if.slave bus
`ifdef FMAC_STAT_EN
    ,
    output logic [15:0] ops_done
`endif
);

    localparam int CntW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateType;

    stateType          state;
    logic              rrPtr;
    logic              grantId;
    logic [CntW-1:0]   cnt;
    logic              grantNext;
    logic              anyValid;
    logic              grantRespReady;
    logic              respDone;

    assign anyValid = bus.req0_valid | bus.req1_valid;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grantNext = rrPtr;
        if (bus.req0_valid && !bus.req1_valid) begin
            grantNext = 1'b0;
        end else if (!bus.req0_valid && bus.req1_valid) begin
            grantNext = 1'b1;
        end
    end

    assign bus.req0_ready = (state == IDLE) && !grantNext && bus.req0_valid;
    assign bus.req1_ready = (state == IDLE) &&  grantNext && bus.req1_valid;

    // Only the granted requester's ready can complete the response.
    assign grantRespReady = grantId ? bus.resp1_ready : bus.resp0_ready;
    assign respDone       = (state == DONE) && grantRespReady;

    assign bus.dp_psign = bus.dp_a[WIDTH-1] ^ bus.dp_b[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rrPtr           <= 1'b0;
            grantId         <= 1'b0;
            cnt             <= '0;
            bus.dp_go       <= 1'b0;
            bus.dp_a        <= '0;
            bus.dp_b        <= '0;
            bus.dp_c        <= '0;
            bus.resp_data   <= '0;
            bus.resp0_valid <= 1'b0;
            bus.resp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.dp_go <= 1'b0;
                    if (anyValid) begin
                        bus.dp_a  <= grantNext ? bus.req1_a : bus.req0_a;
                        bus.dp_b  <= grantNext ? bus.req1_b : bus.req0_b;
                        bus.dp_c  <= grantNext ? bus.req1_c : bus.req0_c;
                        grantId   <= grantNext;
                        cnt       <= '0;
                        bus.dp_go <= 1'b1;
                        state     <= RUN;
                    end
                end

                RUN: begin
                    bus.dp_go <= 1'b0;
                    cnt       <= cnt + CntW'(1);
                    // Last latency cycle: the datapath result is valid now.
                    if (cnt == CntLast) begin
                        bus.resp_data <= bus.dp_res;
                        state         <= DONE;
                        if (grantId) begin
                            bus.resp1_valid <= 1'b1;
                        end else begin
                            bus.resp0_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    bus.dp_go <= 1'b0;
                    if (grantRespReady) begin
                        bus.resp0_valid <= 1'b0;
                        bus.resp1_valid <= 1'b0;
                        rrPtr           <= ~grantId;
                        state           <= IDLE;
                    end
                end

                default: begin
                    bus.dp_go       <= 1'b0;
                    bus.resp0_valid <= 1'b0;
                    bus.resp1_valid <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

`ifdef FMAC_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done <= 16'h0000;
        end else if (respDone) begin
            ops_done <= ops_done + 16'h0001;
        end
    end
`else
    logic unusedRespDone;
    assign unusedRespDone = respDone;
`endif

endmodule

// File: tb/tb_fmac_arb_ctrl.sv
// Scoreboard bench for fmac_arb_ctrl: a^b^c datapath model, expected results queued at accept.
module tb_fmac_arb_ctrl;
    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmac_arb_ctrl_if #(.WIDTH(WIDTH)) bus();

`ifdef FMAC_STAT_EN
    logic [15:0] opsDone;
`endif

    fmac_arb_ctrl #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef FMAC_STAT_EN
        ,
        .ops_done (opsDone)
`endif
    );

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
    } expT;

    expT sbQ[$];
    expT pushE;
    expT popE;
    int  checks      = 0;
    int  errors      = 0;
    int  cyc         = 0;
    int  completions = 0;

    always @(posedge clk) cyc++;

    // Datapath model: result appears LAT-1 cycles after the go pulse is seen.
    int               dpCount;
    logic [WIDTH-1:0] dpVal;
    always @(posedge clk) begin
        if (rst) begin
            dpCount    <= 0;
            bus.dp_res <= 16'hDEAD;
        end else if (bus.dp_go) begin
            dpCount <= LAT - 2;
            dpVal   <= bus.dp_a ^ bus.dp_b ^ bus.dp_c;
        end else if (dpCount != 0) begin
            dpCount <= dpCount - 1;
            if (dpCount == 1) bus.dp_res <= dpVal;
        end else begin
            bus.dp_res <= 16'hDEAD;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            sbQ.delete();
            completions = 0;
        end else begin
            if (bus.req0_valid && bus.req0_ready) begin
                pushE.id = 1'b0;
                pushE.data = bus.req0_a ^ bus.req0_b ^ bus.req0_c;
                sbQ.push_back(pushE);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                pushE.id = 1'b1;
                pushE.data = bus.req1_a ^ bus.req1_b ^ bus.req1_c;
                sbQ.push_back(pushE);
            end
            if (bus.resp0_valid || bus.resp1_valid) begin
                checks++;
                if (bus.resp0_valid && bus.resp1_valid) begin
                    errors++;
                    $display("FAIL both_resp_valid: resp0_valid=1 resp1_valid=1, required at most one");
                end
            end
            if ((bus.resp0_valid && bus.resp0_ready) || (bus.resp1_valid && bus.resp1_ready)) begin
                checks++;
                if (sbQ.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: response data %h with no pending request", bus.resp_data);
                end else begin
                    popE = sbQ.pop_front();
                    if (popE.id !== bus.resp1_valid || popE.data !== bus.resp_data) begin
                        errors++;
                        $display("FAIL sb_resp: got id %0d data %h, required id %0d data %h",
                                 bus.resp1_valid, bus.resp_data, popE.id, popE.data);
                    end
                    completions++;
                end
            end
        end
    end

    task automatic clearInputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_c = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_c = '0;
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        rst = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && !bus.resp0_valid && !bus.resp1_valid) break;
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sbQ.size());
        end
    endtask

    task automatic test_reset();
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (bus.dp_go !== 1'b0)       begin errors++; $display("FAIL reset_dp_go: got %b, required 0", bus.dp_go); end
        if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL reset_resp0_valid: got %b, required 0", bus.resp0_valid); end
        if (bus.resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_resp1_valid: got %b, required 0", bus.resp1_valid); end
        if (bus.dp_a !== 16'h0)       begin errors++; $display("FAIL reset_dp_a: got %h, required 0000", bus.dp_a); end
        if (bus.resp_data !== 16'h0)  begin errors++; $display("FAIL reset_resp_data: got %h, required 0000", bus.resp_data); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.dp_go !== 1'b0)      begin errors++; $display("FAIL post_reset_dp_go: got %b, required 0", bus.dp_go); end
        if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL post_reset_req0_ready: got %b, required 0", bus.req0_ready); end
    endtask

    task automatic test_single_op();
        int t0;
        bit found;
        @(posedge clk); #1;
        bus.req0_a = 16'h3C00; bus.req0_b = 16'hC000; bus.req0_c = 16'h0001;
        bus.req0_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL single_accept: req0_ready never seen, required within 10 cycles"); end
        t0 = cyc;
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        @(negedge clk);
        checks += 4;
        if (bus.dp_go !== 1'b1)    begin errors++; $display("FAIL single_dp_go: got %b, required 1", bus.dp_go); end
        if (bus.dp_psign !== 1'b1) begin errors++; $display("FAIL single_psign: got %b, required 1", bus.dp_psign); end
        if (bus.dp_b !== 16'hC000) begin errors++; $display("FAIL single_dp_b: got %h, required c000", bus.dp_b); end
        if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_run: got %b, required 0", bus.req0_ready); end
        @(negedge clk);
        checks++;
        if (bus.dp_go !== 1'b0) begin errors++; $display("FAIL single_go_pulse: got %b, required 0", bus.dp_go); end
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.resp0_valid) begin found = 1; break; end
            @(negedge clk);
        end
        checks += 4;
        if (!found) begin errors++; $display("FAIL single_resp: resp0_valid never seen"); end
        if (cyc - t0 != LAT + 1) begin errors++; $display("FAIL single_latency: got %0d cycles, required %0d", cyc - t0, LAT + 1); end
        if (bus.resp_data !== 16'hFC01) begin errors++; $display("FAIL single_data: got %h, required fc01", bus.resp_data); end
        if (bus.resp1_valid !== 1'b0) begin errors++; $display("FAIL single_resp1: got %b, required 0", bus.resp1_valid); end
        drain("single");
    endtask

    task automatic test_round_robin();
        int lastT;
        bit found;
        bit gid;
        applyReset();
        bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom); bus.req0_c = 16'($urandom);
        bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom); bus.req1_c = 16'($urandom);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        lastT = 0;
        for (int k = 0; k < 6; k++) begin
            found = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready) begin found = 1; break; end
            end
            gid = bus.req1_ready;
            checks += 2;
            if (!found) begin errors++; $display("FAIL rr_accept%0d: no grant within 20 cycles", k); end
            if (gid !== 1'(k % 2)) begin errors++; $display("FAIL rr_grant%0d: got %0d, required %0d", k, gid, k % 2); end
            if (k > 0) begin
                checks++;
                if (cyc - lastT != LAT + 2) begin
                    errors++; $display("FAIL rr_spacing%0d: got %0d cycles, required %0d", k, cyc - lastT, LAT + 2);
                end
            end
            lastT = cyc;
            @(posedge clk); #1;
            if (gid) begin
                bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom); bus.req1_c = 16'($urandom);
            end else begin
                bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom); bus.req0_c = 16'($urandom);
            end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        drain("rr");
    endtask

    task automatic test_back_pressure();
        logic [WIDTH-1:0] expData;
        bit found;
        @(posedge clk); #1;
        bus.req1_a = 16'h1234; bus.req1_b = 16'h8001; bus.req1_c = 16'h0F0F;
        expData = 16'h1234 ^ 16'h8001 ^ 16'h0F0F;
        bus.req1_valid = 1'b1; bus.resp1_ready = 1'b0; bus.resp0_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req1_ready) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL bp_accept: req1_ready never seen"); end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        bus.req0_a = 16'h0101; bus.req0_b = 16'h0202; bus.req0_c = 16'h0404;
        bus.req0_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.resp1_valid) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL bp_resp: resp1_valid never seen"); end
        for (int i = 0; i < 10; i++) begin
            checks += 4;
            if (bus.resp1_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b, required 1", i, bus.resp1_valid); end
            if (bus.resp_data !== expData) begin errors++; $display("FAIL bp_data%0d: got %h, required %h", i, bus.resp_data, expData); end
            if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_ready%0d: got %b, required 0", i, bus.req0_ready); end
            if (bus.dp_go !== 1'b0) begin errors++; $display("FAIL bp_dp_go%0d: got %b, required 0", i, bus.dp_go); end
            @(negedge clk);
        end
        @(posedge clk); #1 bus.resp1_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL bp_next_accept: req0_ready never seen after release"); end
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        drain("bp");
    endtask

    task automatic test_reset_mid_run();
        bit found;
        bit seen;
        @(posedge clk); #1;
        bus.req0_a = 16'hAAAA; bus.req0_b = 16'h5555; bus.req0_c = 16'h1111;
        bus.req0_valid = 1'b1; bus.resp0_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_accept: req0_ready never seen"); end
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks += 6;
        if (bus.dp_go !== 1'b0)       begin errors++; $display("FAIL mid_dp_go: got %b, required 0", bus.dp_go); end
        if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL mid_resp0_valid: got %b, required 0", bus.resp0_valid); end
        if (bus.dp_a !== 16'h0)       begin errors++; $display("FAIL mid_dp_a: got %h, required 0000", bus.dp_a); end
        if (bus.dp_b !== 16'h0)       begin errors++; $display("FAIL mid_dp_b: got %h, required 0000", bus.dp_b); end
        if (bus.dp_c !== 16'h0)       begin errors++; $display("FAIL mid_dp_c: got %h, required 0000", bus.dp_c); end
        if (bus.resp_data !== 16'h0)  begin errors++; $display("FAIL mid_resp_data: got %h, required 0000", bus.resp_data); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.resp0_valid || bus.resp1_valid) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_discard: resp_valid seen after reset, required none"); end
        @(posedge clk); #1;
        bus.req1_a = 16'h7777; bus.req1_b = 16'h0F00; bus.req1_c = 16'h0003;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL mid_req1_accept: got %b, required 1", bus.req1_ready); end
        @(posedge clk); #1 bus.req1_valid = 1'b0;
        drain("mid");
    endtask

    task automatic test_operand_stability();
        bit found;
        @(posedge clk); #1;
        bus.req0_a = 16'h1111; bus.req0_b = 16'h0002; bus.req0_c = 16'h0003;
        bus.req0_valid = 1'b1; bus.resp0_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL stab_accept: req0_ready never seen"); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req0_a = 16'h2222;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus.dp_a !== 16'h1111) begin errors++; $display("FAIL stab_busy%0d: dp_a %h, required 1111", i, bus.dp_a); end
        end
        @(posedge clk); #1 bus.resp0_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dp_a !== 16'h1111) begin errors++; $display("FAIL stab_idle: dp_a %h, required 1111", bus.dp_a); end
        @(posedge clk); #1 bus.req0_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin found = 1; break; end
        end
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (!found) begin errors++; $display("FAIL stab_reaccept: req0_ready never seen"); end
        if (bus.dp_a !== 16'h2222) begin errors++; $display("FAIL stab_new: dp_a %h, required 2222", bus.dp_a); end
        drain("stab");
    endtask

`ifdef FMAC_STAT_EN
    task automatic test_stats();
        @(negedge clk);
        checks++;
        if (opsDone !== 16'(completions)) begin
            errors++; $display("FAIL stats_ops_done: got %0d, required %0d", opsDone, completions);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_run();
        test_operand_stability();
`ifdef FMAC_STAT_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
